// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. Signal names carry the controller's view (_i in, _o out).
interface multicycle_ctrl_if;
  logic [6:0] opcode_i;
  logic [2:0] funct3_i;
  logic [6:0] funct7_i;
  logic       br_taken_i;
  logic       imem_req_o;
  logic       imem_ack_i;
  logic       dmem_req_o;
  logic       dmem_we_o;
  logic       dmem_ack_i;
  logic       ir_we_o;
  logic       pc_we_o;
  logic [1:0] pc_sel_o;
  logic [2:0] imm_sel_o;
  logic       alu_a_sel_o;
  logic       alu_b_sel_o;
  logic [3:0] alu_op_o;
  logic       rf_we_o;
  logic [1:0] wb_sel_o;
  logic       illegal_o;
  logic       timeout_o;
  logic [2:0] state_o;

  modport master (
    input  opcode_i, funct3_i, funct7_i, br_taken_i, imem_ack_i, dmem_ack_i,
    output imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, pc_sel_o, imm_sel_o,
           alu_a_sel_o, alu_b_sel_o, alu_op_o, rf_we_o, wb_sel_o, illegal_o, timeout_o, state_o
  );
  modport slave (
    output opcode_i, funct3_i, funct7_i, br_taken_i, imem_ack_i, dmem_ack_i,
    input  imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, pc_sel_o, imm_sel_o,
           alu_a_sel_o, alu_b_sel_o, alu_op_o, rf_we_o, wb_sel_o, illegal_o, timeout_o, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing with memory-ack timeout trap.
// Outputs are decoded from state; all of them are held at 0 while rst_ni is low.
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  multicycle_ctrl_if.master bus
);
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM   = 3'd3, S_WB     = 3'd4, S_TRAP = 3'd5;
  localparam logic [3:0] C_OP = 4'd0, C_OPIMM = 4'd1, C_LUI = 4'd2, C_AUIPC = 4'd3, C_JAL = 4'd4,
                         C_JALR = 4'd5, C_BR = 4'd6, C_LD = 4'd7, C_ST = 4'd8, C_FENCE = 4'd9, C_ILL = 4'd10;
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;
  localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

  function automatic logic [3:0] classify(input logic [6:0] opc);
    case (opc)
      7'b0110011: return C_OP;
      7'b0010011: return C_OPIMM;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b1100011: return C_BR;
      7'b0000011: return C_LD;
      7'b0100011: return C_ST;
      7'b0001111: return C_FENCE;
      default:    return C_ILL;  // includes SYSTEM
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [3:0] c);
    case (c)
      C_ST:          return IMM_S;
      C_BR:          return IMM_B;
      C_LUI, C_AUIPC: return IMM_U;
      C_JAL:         return IMM_J;
      default:       return IMM_I;
    endcase
  endfunction

  logic [2:0]    state_q, state_d;
  logic [3:0]    cls_q, cls_d, cls_cur;
  logic          ill_q, ill_d, to_q, to_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wait_hit;
  logic          imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, a_sel, b_sel;
  logic [1:0]    pc_sel, wb_sel;
  logic [2:0]    imm_sel;
  logic [3:0]    alu_op;
  logic          unused_funct7;

  assign unused_funct7 = ^{bus.funct7_i[6], bus.funct7_i[4:0]};
  // Class is taken live from the decoder during DECODE and from the register afterwards.
  assign cls_cur  = (state_q == S_DECODE) ? classify(bus.opcode_i) : cls_q;
  assign wait_hit = (MEM_WAIT_MAX != 0) && (cnt_q == LAST);

  always_comb begin
    state_d = state_q; cls_d = cls_q; ill_d = ill_q; to_d = to_q; cnt_d = '0;
    imem_req = 1'b0; dmem_req = 1'b0; dmem_we = 1'b0; ir_we = 1'b0; pc_we = 1'b0; rf_we = 1'b0;
    a_sel = 1'b0; b_sel = 1'b0; pc_sel = 2'd0; wb_sel = 2'd0; imm_sel = 3'd0; alu_op = 4'd0;
    if (rst_ni) begin
      if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) imm_sel = imm_of(cls_cur);
      if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
        a_sel = (cls_q == C_AUIPC);
        b_sel = (cls_q inside {C_OPIMM, C_LD, C_ST, C_AUIPC, C_JALR});
        // Immediate ALU ops only carry funct7[5] for the shift-right pair.
        if (cls_q == C_OP) alu_op = {bus.funct7_i[5], bus.funct3_i};
        else if (cls_q == C_OPIMM) alu_op = {(bus.funct3_i == 3'b101) & bus.funct7_i[5], bus.funct3_i};
      end
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (bus.imem_ack_i) begin
            ir_we = 1'b1; state_d = S_DECODE;
          end else if (wait_hit) begin
            state_d = S_TRAP; to_d = 1'b1;
          end else cnt_d = cnt_q + 1'b1;
        end
        S_DECODE: begin
          cls_d = cls_cur;
          if (cls_cur == C_ILL) begin
            state_d = S_TRAP; ill_d = 1'b1;
          end else state_d = S_EXEC;
        end
        S_EXEC: begin
          case (cls_q)
            C_BR:       begin pc_we = 1'b1; pc_sel = bus.br_taken_i ? 2'd1 : 2'd0; state_d = S_FETCH; end
            C_FENCE:    begin pc_we = 1'b1; state_d = S_FETCH; end
            C_LD, C_ST: state_d = S_MEM;
            default:    state_d = S_WB;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == C_ST);
          if (bus.dmem_ack_i) begin
            if (cls_q == C_ST) begin pc_we = 1'b1; state_d = S_FETCH; end
            else state_d = S_WB;
          end else if (wait_hit) begin
            state_d = S_TRAP; to_d = 1'b1;
          end else cnt_d = cnt_q + 1'b1;
        end
        S_WB: begin
          rf_we = 1'b1; pc_we = 1'b1; state_d = S_FETCH;
          case (cls_q)
            C_LD:          wb_sel = 2'd1;
            C_JAL, C_JALR: wb_sel = 2'd2;
            C_LUI:         wb_sel = 2'd3;
            default:       wb_sel = 2'd0;
          endcase
          if (cls_q == C_JAL) pc_sel = 2'd1;
          else if (cls_q == C_JALR) pc_sel = 2'd2;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FETCH; cls_q <= C_OP; ill_q <= 1'b0; to_q <= 1'b0; cnt_q <= '0;
    end else begin
      state_q <= state_d; cls_q <= cls_d; ill_q <= ill_d; to_q <= to_d; cnt_q <= cnt_d;
    end
  end

  assign bus.imem_req_o  = imem_req;
  assign bus.dmem_req_o  = dmem_req;
  assign bus.dmem_we_o   = dmem_we;
  assign bus.ir_we_o     = ir_we;
  assign bus.pc_we_o     = pc_we;
  assign bus.pc_sel_o    = pc_sel;
  assign bus.imm_sel_o   = imm_sel;
  assign bus.alu_a_sel_o = a_sel;
  assign bus.alu_b_sel_o = b_sel;
  assign bus.alu_op_o    = alu_op;
  assign bus.rf_we_o     = rf_we;
  assign bus.wb_sel_o    = wb_sel;
  assign bus.illegal_o   = ill_q;
  assign bus.timeout_o   = to_q;
  assign bus.state_o     = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle traces built from opcode rules, random mix + directed cases.
module tb_multicycle_ctrl;
  localparam int W = 4;
  localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6F, OPC_JALR = 7'h67, OPC_BR = 7'h63,
                         OPC_LD = 7'h03, OPC_ST = 7'h23, OPC_OPI = 7'h13, OPC_OP = 7'h33, OPC_FENCE = 7'h0F;

  typedef struct packed {
    logic [2:0] st; logic ireq, dreq, dwe, irwe, pcwe; logic [1:0] pcsel; logic [2:0] imm;
    logic asel, bsel; logic [3:0] aop; logic rfwe; logic [1:0] wbsel; logic ill, to;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();
  multicycle_ctrl #(.MEM_WAIT_MAX(W)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int checks = 0, errors = 0;
  logic [6:0] cur_opc = '0, cur_f7 = '0;
  logic [2:0] cur_f3 = '0;
  int obs_ireq, obs_dreq, obs_dwe, obs_rfwe, obs_pcwe, last_pcsel, last_wbsel, last_imm;
  logic [6:0] ops [10] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BR, OPC_LD, OPC_ST, OPC_OPI, OPC_OP, OPC_FENCE};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit legal(input logic [6:0] o);
    for (int i = 0; i < 10; i++) if (ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] imm_exp(input logic [6:0] o);
    if (o == OPC_ST) return 3'd1;
    if (o == OPC_BR) return 3'd2;
    if (o == OPC_LUI || o == OPC_AUIPC) return 3'd3;
    if (o == OPC_JAL) return 3'd4;
    return 3'd0;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a.st = bus.state_o; a.ireq = bus.imem_req_o; a.dreq = bus.dmem_req_o; a.dwe = bus.dmem_we_o;
    a.irwe = bus.ir_we_o; a.pcwe = bus.pc_we_o; a.pcsel = bus.pc_sel_o; a.imm = bus.imm_sel_o;
    a.asel = bus.alu_a_sel_o; a.bsel = bus.alu_b_sel_o; a.aop = bus.alu_op_o; a.rfwe = bus.rf_we_o;
    a.wbsel = bus.wb_sel_o; a.ill = bus.illegal_o; a.to = bus.timeout_o;
    return a;
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin errors++; $display("FAIL %s got %0d want %0d", n, act, exp); end
  endtask

  task automatic chk_vec(input string n, input exp_t e);
    exp_t a = actual();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s opc=%h got st=%0d vec=%h want st=%0d vec=%h", n, cur_opc, a.st, a, e.st, e);
    end
  endtask

  task automatic step(input exp_t e, input logic ia, input logic da, input logic br, input string tag);
    exp_t a;
    @(negedge clk);
    bus.opcode_i = cur_opc; bus.funct3_i = cur_f3; bus.funct7_i = cur_f7;
    bus.imem_ack_i = ia; bus.dmem_ack_i = da; bus.br_taken_i = br;
    #1;
    chk_vec(tag, e);
    a = actual();
    obs_ireq += int'(a.ireq); obs_dreq += int'(a.dreq); obs_dwe += int'(a.dreq & a.dwe);
    obs_rfwe += int'(a.rfwe); obs_pcwe += int'(a.pcwe);
    if (a.pcwe) last_pcsel = int'(a.pcsel);
    if (a.rfwe) last_wbsel = int'(a.wbsel);
    if (a.dreq) last_imm = int'(a.imm);
  endtask

  task automatic trap_cycles(input int n, input logic ill, input logic to);
    exp_t e = '0;
    e.st = 3'd5; e.ill = ill; e.to = to;
    for (int i = 0; i < n; i++) step(e, rb(), rb(), rb(), "trap");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.imem_ack_i = 1'b0; bus.dmem_ack_i = 1'b0;
    #1 chk_vec("in_reset", '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Expected trace of one instruction; wf/wm = ack-less cycles before the fetch/data ack.
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7, input logic br,
                           input int wf, input int wm, input bit stop_mem, output int ncyc, output bit trapped);
    exp_t e;
    bit is_st = (opc == OPC_ST), is_ld = (opc == OPC_LD);
    cur_opc = opc; cur_f3 = f3; cur_f7 = f7;
    obs_ireq = 0; obs_dreq = 0; obs_dwe = 0; obs_rfwe = 0; obs_pcwe = 0;
    last_pcsel = -1; last_wbsel = -1; last_imm = -1; ncyc = 0; trapped = 1'b0;
    for (int k = 0; k < wf && k < W; k++) begin
      e = '0; e.ireq = 1'b1; step(e, 1'b0, rb(), rb(), "fetch_wait"); ncyc++;
    end
    if (wf >= W) begin trapped = 1'b1; trap_cycles(3, 1'b0, 1'b1); return; end
    e = '0; e.ireq = 1'b1; e.irwe = 1'b1; step(e, 1'b1, rb(), rb(), "fetch_ack"); ncyc++;
    e = '0; e.st = 3'd1; e.imm = imm_exp(opc); step(e, rb(), rb(), rb(), "decode"); ncyc++;
    if (!legal(opc)) begin trapped = 1'b1; trap_cycles(3, 1'b1, 1'b0); return; end
    e.st = 3'd2;
    e.asel = (opc == OPC_AUIPC);
    e.bsel = (opc == OPC_OPI || is_ld || is_st || opc == OPC_AUIPC || opc == OPC_JALR);
    if (opc == OPC_OP) e.aop = {f7[5], f3};
    else if (opc == OPC_OPI) e.aop = {f3 == 3'b101 && f7[5], f3};
    if (opc == OPC_BR || opc == OPC_FENCE) begin
      e.pcwe = 1'b1; e.pcsel = (opc == OPC_BR && br) ? 2'd1 : 2'd0;
      step(e, rb(), rb(), br, "exec_pc"); ncyc++;
      return;
    end
    step(e, rb(), rb(), rb(), "exec"); ncyc++;
    if (is_ld || is_st) begin
      e.st = 3'd3; e.dreq = 1'b1; e.dwe = is_st;
      for (int k = 0; k < wm && k < W; k++) begin
        step(e, rb(), 1'b0, rb(), "mem_wait"); ncyc++;
        if (stop_mem) return;
      end
      if (wm >= W) begin trapped = 1'b1; trap_cycles(3, 1'b0, 1'b1); return; end
      e.pcwe = is_st; step(e, rb(), 1'b1, rb(), "mem_ack"); ncyc++;
      if (is_st) return;
      e.dreq = 1'b0; e.dwe = 1'b0;
    end
    e.st = 3'd4; e.rfwe = 1'b1; e.pcwe = 1'b1;
    e.wbsel = is_ld ? 2'd1 : (opc == OPC_JAL || opc == OPC_JALR) ? 2'd2 : (opc == OPC_LUI) ? 2'd3 : 2'd0;
    e.pcsel = (opc == OPC_JAL) ? 2'd1 : (opc == OPC_JALR) ? 2'd2 : 2'd0;
    step(e, rb(), rb(), rb(), "wb"); ncyc++;
  endtask

  initial begin
    int nc;
    bit tr;
    logic [6:0] opc;
    int wf, wm;
    bus.opcode_i = '0; bus.funct3_i = '0; bus.funct7_i = '0;
    bus.br_taken_i = 1'b0; bus.imem_ack_i = 1'b0; bus.dmem_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_vec("reset_state", '0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD x3,x1,x2
    run_instr(7'h33, 3'd0, 7'd0, 1'b0, 0, 0, 1'b0, nc, tr);
    chk("add_cycles", nc, 4); chk("add_rf_we", obs_rfwe, 1); chk("add_wb_sel", last_wbsel, 0);
    chk("add_pc_sel", last_pcsel, 0);
    // LW x5,8(x1), data ack 3 cycles late
    run_instr(7'h03, 3'd2, 7'd0, 1'b0, 0, 3, 1'b0, nc, tr);
    chk("lw_cycles", nc, 8); chk("lw_dreq_cycles", obs_dreq, 4); chk("lw_dwe", obs_dwe, 0);
    chk("lw_imm_sel", last_imm, 0); chk("lw_wb_sel", last_wbsel, 1);
    // BEQ taken / not taken
    run_instr(7'h63, 3'd0, 7'd0, 1'b1, 0, 0, 1'b0, nc, tr);
    chk("beq_t_cycles", nc, 3); chk("beq_t_pc_sel", last_pcsel, 1); chk("beq_t_rf_we", obs_rfwe, 0);
    run_instr(7'h63, 3'd0, 7'd0, 1'b0, 0, 0, 1'b0, nc, tr);
    chk("beq_n_pc_sel", last_pcsel, 0); chk("beq_n_pc_we", obs_pcwe, 1);
    // SW, SRAI
    run_instr(7'h23, 3'd2, 7'd0, 1'b0, 0, 0, 1'b0, nc, tr);
    chk("sw_cycles", nc, 4); chk("sw_dwe", obs_dwe, 1);
    // fetch ack on the last allowed cycle does not trap
    run_instr(7'h13, 3'd5, 7'h20, 1'b0, W - 1, 0, 1'b0, nc, tr);
    chk("late_ack_trap", int'(tr), 0); chk("late_ack_cycles", nc, 7);
    // illegal opcode
    run_instr(7'h7F, 3'd0, 7'd0, 1'b0, 0, 0, 1'b0, nc, tr);
    obs_ireq = 0;
    trap_cycles(20, 1'b1, 1'b0);
    chk("ill_ireq", obs_ireq, 0); chk("ill_flag", int'(bus.illegal_o), 1);
    do_reset();
    // fetch timeout
    run_instr(7'h33, 3'd0, 7'd0, 1'b0, W, 0, 1'b0, nc, tr);
    chk("to_ireq_cycles", obs_ireq, 4); chk("to_state", int'(bus.state_o), 5); chk("to_flag", int'(bus.timeout_o), 1);
    do_reset();
    // reset while a load is waiting in MEM
    run_instr(7'h03, 3'd2, 7'd0, 1'b0, 0, 3, 1'b1, nc, tr);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_dmem_req", int'(bus.dmem_req_o), 0);
    chk_vec("rst_mid_mem", '0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 13))
        10:      opc = 7'h73;
        11:      opc = 7'h7F;
        12:      opc = 7'($urandom_range(0, 127));
        13:      opc = OPC_OP;
        default: opc = ops[$urandom_range(0, 9)];
      endcase
      wf = ($urandom_range(0, 15) == 0) ? W + $urandom_range(0, 1) : $urandom_range(0, W - 1);
      wm = ($urandom_range(0, 15) == 0) ? W : $urandom_range(0, W - 1);
      run_instr(opc, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), rb(), wf, wm, 1'b0, nc, tr);
      if (tr) do_reset();
      else chk("one_pc_we", obs_pcwe, 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
